// File: rtl/counter_sched_pkg.sv
// Shared opcode and FSM state definitions for the round-robin counter scheduler.
// Imported by the scheduler top and its testbench.
package counter_sched_pkg;

  localparam logic [1:0] OP_INC  = 2'b00;
  localparam logic [1:0] OP_DEC  = 2'b01;
  localparam logic [1:0] OP_LOAD = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_ACK  = 2'b10
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set req bit strictly after the last
// grant, wrapping modulo N_REQ; the last-granted requester is checked last.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  // scan from last+1 upward; the first hit wins and later hits are masked
  always_comb begin
    int               cand_s;
    logic [IDX_W-1:0] cidx_s;
    logic             hit_s;
    valid  = 1'b0;
    idx    = last;
    cand_s = 0;
    cidx_s = {IDX_W{1'b0}};
    hit_s  = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand_s = (int'(last) + k) % N_REQ;
      cidx_s = IDX_W'(cand_s);
      hit_s  = req[cidx_s] & ~valid;
      valid  = valid | hit_s;
      idx    = hit_s ? cidx_s : idx;
    end
  end

endmodule

// File: rtl/counter_sched.sv
// Shares one WIDTH-bit counter among N_REQ requesters: IDLE grants round-robin,
// EXEC applies the latched op, ACK pulses the one-hot completion.
module counter_sched
  import counter_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [2*N_REQ-1:0]     op,
  input  logic [WIDTH*N_REQ-1:0] data,
  output logic [N_REQ-1:0]       ack,
  output logic [WIDTH-1:0]       value,
  output logic                   wrap,
  output logic                   busy,
  output logic [IDX_W-1:0]       gnt_idx
);

  state_t           state_r, state_nx_s;
  logic [1:0]       op_r;
  logic [WIDTH-1:0] data_r;
  logic [WIDTH-1:0] value_r, value_nx_s;
  logic             wrap_r, wrap_nx_s;
  logic [N_REQ-1:0] ack_r, ack_nx_s;
  logic             busy_r;
  logic [IDX_W-1:0] gnt_idx_r;
  logic             win_vld_s;
  logic [IDX_W-1:0] win_idx_s;

  logic [1:0]       op_arr_s   [N_REQ];
  logic [WIDTH-1:0] data_arr_s [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_slice
    assign op_arr_s[g]   = op[2*g +: 2];
    assign data_arr_s[g] = data[WIDTH*g +: WIDTH];
  end

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req   (req),
    .last  (gnt_idx_r),
    .valid (win_vld_s),
    .idx   (win_idx_s)
  );

  // next-state logic; req only matters in IDLE
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (win_vld_s) state_nx_s = ST_EXEC;
        else           state_nx_s = ST_IDLE;
      end
      ST_EXEC: state_nx_s = ST_ACK;
      ST_ACK:  state_nx_s = ST_IDLE;
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // counter datapath; wrap only from arithmetic overflow, never LOAD/CLEAR
  always_comb begin
    value_nx_s = value_r;
    wrap_nx_s  = 1'b0;
    if (state_r == ST_EXEC) begin
      case (op_r)
        OP_INC: begin
          value_nx_s = value_r + WIDTH'(1);
          wrap_nx_s  = &value_r;
        end
        OP_DEC: begin
          value_nx_s = value_r - WIDTH'(1);
          wrap_nx_s  = ~|value_r;
        end
        OP_LOAD: value_nx_s = data_r;
        OP_CLR:  value_nx_s = {WIDTH{1'b0}};
        default: value_nx_s = value_r;
      endcase
    end else begin
      value_nx_s = value_r;
    end
  end

  // completion pulse lands in the cycle after EXEC
  always_comb begin
    ack_nx_s = {N_REQ{1'b0}};
    if (state_r == ST_EXEC) ack_nx_s[gnt_idx_r] = 1'b1;
    else                    ack_nx_s = {N_REQ{1'b0}};
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_r <= ST_IDLE;
    else        state_r <= state_nx_s;
  end

  // counter, output and grant-latch registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value_r   <= {WIDTH{1'b0}};
      wrap_r    <= 1'b0;
      ack_r     <= {N_REQ{1'b0}};
      busy_r    <= 1'b0;
      op_r      <= OP_INC;
      data_r    <= {WIDTH{1'b0}};
      gnt_idx_r <= IDX_W'(N_REQ - 1);
    end else begin
      value_r <= value_nx_s;
      wrap_r  <= wrap_nx_s;
      ack_r   <= ack_nx_s;
      busy_r  <= (state_nx_s != ST_IDLE);
      if (state_r == ST_IDLE && win_vld_s) begin
        op_r      <= op_arr_s[win_idx_s];
        data_r    <= data_arr_s[win_idx_s];
        gnt_idx_r <= win_idx_s;
      end else begin
        op_r      <= op_r;
        data_r    <= data_r;
        gnt_idx_r <= gnt_idx_r;
      end
    end
  end

  assign ack     = ack_r;
  assign value   = value_r;
  assign wrap    = wrap_r;
  assign busy    = busy_r;
  assign gnt_idx = gnt_idx_r;

endmodule

// File: tb/tb_counter_sched.sv
// Scoreboard bench for counter_sched: expected completions are queued at
// stimulus time and popped by a monitor whenever ack is seen.
module tb_counter_sched;
  import counter_sched_pkg::*;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [7:0]  op;
  logic [31:0] data;
  logic [3:0]  ack;
  logic [7:0]  value;
  logic        wrap;
  logic        busy;
  logic [1:0]  gnt_idx;

  typedef struct packed {
    logic [1:0] idx;
    logic [7:0] val;
    logic       wrap;
  } exp_t;

  exp_t sb[$];
  exp_t e_m;
  int   n_cmp = 0;
  int   n_err = 0;

  counter_sched #(.N_REQ(4), .WIDTH(8), .IDX_W(2)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .op      (op),
    .data    (data),
    .ack     (ack),
    .value   (value),
    .wrap    (wrap),
    .busy    (busy),
    .gnt_idx (gnt_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // monitor: every ack pops one expectation; wrap must be quiet otherwise
  always @(negedge clk) begin
    if (reset && ack != 4'b0000) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_ack ack=%b value=%h, required no ack", ack, value);
      end else begin
        e_m = sb.pop_front();
        if (ack !== (4'b0001 << e_m.idx) || value !== e_m.val ||
            wrap !== e_m.wrap || gnt_idx !== e_m.idx) begin
          n_err++;
          $display("FAIL txn ack=%b value=%h wrap=%b gnt=%0d, required ack=%b value=%h wrap=%b gnt=%0d",
                   ack, value, wrap, gnt_idx, 4'b0001 << e_m.idx, e_m.val, e_m.wrap, e_m.idx);
        end
      end
    end else if (reset) begin
      n_cmp++;
      if (wrap !== 1'b0) begin
        n_err++;
        $display("FAIL stray_wrap wrap=%b, required 0", wrap);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [1:0] o, input logic [7:0] d);
    op[2*i +: 2]   = o;
    data[8*i +: 8] = d;
  endtask

  task automatic expect_txn(input logic [1:0] i, input logic [7:0] v, input logic w);
    exp_t e;
    e.idx  = i;
    e.val  = v;
    e.wrap = w;
    sb.push_back(e);
  endtask

  // run until n acks; hold keeps req high across acks, mut rewrites a slice during EXEC
  task automatic run(input int n, input bit hold, input int mut);
    int seen = 0;
    int it   = 0;
    int last = 0;
    while (seen < n && it < 40) begin
      @(posedge clk);
      #1;
      it++;
      if (it == 1) begin
        chk("busy_exec", {31'd0, busy}, 32'd1);
        if (mut >= 0) set_op(mut, OP_LOAD, 8'h99);
      end
      if (ack != 4'b0000) begin
        if (seen == 0) chk("ack_latency", it, 32'd2);
        else           chk("ack_spacing", it - last, 32'd3);
        last = it;
        seen++;
        if (!hold) req = req & ~ack;
      end
    end
    if (seen < n) begin
      n_cmp++;
      n_err++;
      $display("FAIL ack_timeout seen=%0d required=%0d", seen, n);
    end
    req = 4'b0000;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    req   = 4'b0000;
    op    = 8'h00;
    data  = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_value", {24'd0, value}, 32'h00);
    chk("rst_ack",   {28'd0, ack},   32'h0);
    chk("rst_wrap",  {31'd0, wrap},  32'h0);
    chk("rst_busy",  {31'd0, busy},  32'h0);
    chk("rst_gnt",   {30'd0, gnt_idx}, 32'd3);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // 1: single INC from reset
    set_op(0, OP_INC, 8'h00);
    expect_txn(2'd0, 8'h01, 1'b0);
    req = 4'b0001;
    run(1, 1'b0, -1);

    // 2: LOAD all-ones, INC wraps to 0, DEC wraps back to all-ones
    set_op(0, OP_LOAD, 8'hFF);
    expect_txn(2'd0, 8'hFF, 1'b0);
    req = 4'b0001;
    run(1, 1'b0, -1);
    set_op(0, OP_INC, 8'h00);
    expect_txn(2'd0, 8'h00, 1'b1);
    req = 4'b0001;
    run(1, 1'b0, -1);
    set_op(0, OP_DEC, 8'h00);
    expect_txn(2'd0, 8'hFF, 1'b1);
    req = 4'b0001;
    run(1, 1'b0, -1);

    // 3: all requesters held high from reset rotate 0,1,2,3,0
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) set_op(i, OP_INC, 8'h00);
    expect_txn(2'd0, 8'h01, 1'b0);
    expect_txn(2'd1, 8'h02, 1'b0);
    expect_txn(2'd2, 8'h03, 1'b0);
    expect_txn(2'd3, 8'h04, 1'b0);
    expect_txn(2'd0, 8'h05, 1'b0);
    req = 4'b1111;
    run(5, 1'b1, -1);

    // 4: LOAD 0x37 via req1, then req2 CLEAR with op/data rewritten during EXEC
    set_op(1, OP_LOAD, 8'h37);
    expect_txn(2'd1, 8'h37, 1'b0);
    req = 4'b0010;
    run(1, 1'b0, -1);
    set_op(2, OP_CLR, 8'h55);
    expect_txn(2'd2, 8'h00, 1'b0);
    req = 4'b0100;
    run(1, 1'b0, 2);
    chk("clr_value", {24'd0, value}, 32'h00);

    // 5: reset during EXEC of LOAD 0xAA aborts the transaction
    set_op(0, OP_INC, 8'h00);
    expect_txn(2'd0, 8'h01, 1'b0);
    req = 4'b0001;
    run(1, 1'b0, -1);
    set_op(3, OP_LOAD, 8'hAA);
    req = 4'b1000;
    @(posedge clk);
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    chk("abort_value", {24'd0, value}, 32'h00);
    chk("abort_ack",   {28'd0, ack},   32'h0);
    chk("abort_busy0", {31'd0, busy},  32'h0);
    chk("abort_gnt",   {30'd0, gnt_idx}, 32'd3);
    req = 4'b0000;
    @(posedge clk);
    #1;
    chk("abort_noack", {28'd0, ack}, 32'h0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    set_op(1, OP_INC, 8'h00);
    set_op(3, OP_INC, 8'h00);
    expect_txn(2'd1, 8'h01, 1'b0);
    expect_txn(2'd3, 8'h02, 1'b0);
    req = 4'b1010;
    run(2, 1'b0, -1);

    // 6: req1 held across its ack is granted again three cycles later
    set_op(1, OP_INC, 8'h00);
    expect_txn(2'd1, 8'h03, 1'b0);
    expect_txn(2'd1, 8'h04, 1'b0);
    req = 4'b0010;
    run(2, 1'b1, -1);

    repeat (6) @(posedge clk);
    #1;
    chk("sb_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
